// File: rtl/siso_pkg.sv
// rtl/siso_pkg.sv - shared types, constants and metric arithmetic for the SISO beta unit
// Contents: metric width and block limits, FSM state enum, metric_t and
// metric_vec_t, smax() signed max, beta_init() terminated start vector,
// beta_step() one normalized backward trellis step for the 8-state LTE code.
package siso_pkg;

   localparam int MW         = 16;
   localparam int MAX_LEN    = 6144;
   localparam int LW         = 13;    // wide enough to hold MAX_LEN itself
   localparam int NUM_STATES = 8;

   typedef logic signed [MW-1:0] metric_t;
   typedef metric_t [NUM_STATES-1:0] metric_vec_t;

   localparam metric_t NEG_INIT = metric_t'(-128);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PRIME,
      ST_RUN
   } state_e;

   // Signed max; on a tie the first operand wins.
   function automatic metric_t smax(input metric_t a, input metric_t b);
      return (b > a) ? b : a;
   endfunction

   // Terminated trellis: only state 0 is reachable at k = N.
   function automatic metric_vec_t beta_init();
      metric_vec_t v;
      for (int i = 0; i < NUM_STATES; i++) begin
         v[i] = (i == 0) ? metric_t'(0) : NEG_INIT;
      end
      return v;
   endfunction

   // beta_k from beta_{k+1} and gamma_k, all sums wrap at MW bits.
   // The result is normalized so that state 0 is always zero.
   function automatic metric_vec_t beta_step(input metric_vec_t b,
                                             input metric_t g1,
                                             input metric_t g2);
      metric_vec_t nb;
      metric_vec_t r;
      nb[0] = smax(metric_t'(b[0] + g1), metric_t'(b[4] - g1));
      nb[1] = smax(metric_t'(b[0] - g1), metric_t'(b[4] + g1));
      nb[2] = smax(metric_t'(b[1] - g2), metric_t'(b[5] + g2));
      nb[3] = smax(metric_t'(b[1] + g2), metric_t'(b[5] - g2));
      nb[4] = smax(metric_t'(b[2] + g2), metric_t'(b[6] - g2));
      nb[5] = smax(metric_t'(b[2] - g2), metric_t'(b[6] + g2));
      nb[6] = smax(metric_t'(b[3] - g1), metric_t'(b[7] + g1));
      nb[7] = smax(metric_t'(b[3] + g1), metric_t'(b[7] - g1));
      for (int i = 0; i < NUM_STATES; i++) begin
         r[i] = nb[i] - nb[0];
      end
      return r;
   endfunction

endpackage

// File: rtl/beta_recursion_if.sv
// rtl/beta_recursion_if.sv - control, branch-input and beta-output bundle of beta_recursion
// master: block controller / upstream / downstream side (drives start, blk_len,
//         in_valid, init_branch1/2, out_ready).
// slave:  beta_recursion (drives in_ready, out_valid, beta_0..7,
//         out_branch1/2, out_idx, out_last, busy).
interface beta_recursion_if;
   import siso_pkg::*;

   logic            start;
   logic [LW-1:0]   blk_len;
   logic            in_valid;
   logic            in_ready;
   metric_t         init_branch1;
   metric_t         init_branch2;
   logic            out_valid;
   logic            out_ready;
   metric_t         beta_0;
   metric_t         beta_1;
   metric_t         beta_2;
   metric_t         beta_3;
   metric_t         beta_4;
   metric_t         beta_5;
   metric_t         beta_6;
   metric_t         beta_7;
   metric_t         out_branch1;
   metric_t         out_branch2;
   logic [LW-1:0]   out_idx;
   logic            out_last;
   logic            busy;

   modport master (
      output start, blk_len, in_valid, init_branch1, init_branch2, out_ready,
      input  in_ready, out_valid, beta_0, beta_1, beta_2, beta_3, beta_4,
             beta_5, beta_6, beta_7, out_branch1, out_branch2, out_idx,
             out_last, busy
   );

   modport slave (
      input  start, blk_len, in_valid, init_branch1, init_branch2, out_ready,
      output in_ready, out_valid, beta_0, beta_1, beta_2, beta_3, beta_4,
             beta_5, beta_6, beta_7, out_branch1, out_branch2, out_idx,
             out_last, busy
   );

endinterface

// File: rtl/branch_lifo_ram.sv
// rtl/branch_lifo_ram.sv - simple dual-port RAM holding one block of branch metric pairs
// Ports: clk; write side wr_en_i/wr_addr_i/wr_data_i; read side rd_en_i/rd_addr_i,
// rd_data_o registered one cycle after rd_en_i and held while rd_en_i is low.
// Used as a LIFO: written at ascending addresses, read back at descending ones.
module branch_lifo_ram #(
   parameter int DW    = 32,
   parameter int DEPTH = 6144,
   parameter int AW    = 13
) (
   input  logic          clk,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [DW-1:0] rd_data_o
);

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rd_data_q;

   // No reset: contents and read register are don't-care until written/read.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/beta_recursion.sv
// rtl/beta_recursion.sv - backward state-metric (beta) unit of the max-log-MAP SISO decoder
// Ports: clk, rst (async, active-high), bus (beta_recursion_if.slave).
// Loads N branch pairs into a LIFO, then replays them k = N-1..0 and emits
// beta_{k+1} with gamma_k on each beat. Pipeline: LIFO read register (stage 1)
// feeds the output register; both advance only when the output is empty or taken.
module beta_recursion
   import siso_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   beta_recursion_if.slave bus
);

   localparam int DW = 2 * MW;

   state_e        state_q;
   logic [LW-1:0] len_q;
   logic [LW-1:0] wr_ptr_q;
   logic [LW-1:0] rd_ptr_q;      // next LIFO address to read
   logic          rd_more_q;     // addresses still left to read
   logic          s1_q;          // LIFO read register holds a pending beat
   logic [LW-1:0] s1_idx_q;
   logic          in_ready_q;
   logic          busy_q;
   logic          out_valid_q;
   logic          out_last_q;
   logic [LW-1:0] out_idx_q;
   metric_vec_t   beta_q;
   metric_t       ob1_q;
   metric_t       ob2_q;

   logic          blk_ok;
   logic          wr_en;
   logic          rd_en;
   logic          advance;
   logic [LW-1:0] rd_addr;
   logic [DW-1:0] rd_data;

   assign blk_ok = (bus.blk_len != '0) && (bus.blk_len <= LW'(MAX_LEN));

   always_comb begin
      advance = !out_valid_q || bus.out_ready;
      wr_en   = in_ready_q && bus.in_valid;
      rd_en   = 1'b0;
      rd_addr = rd_ptr_q;
      case (state_q)
         ST_PRIME: begin
            rd_en   = 1'b1;
            rd_addr = len_q - LW'(1);
         end
         // Refill stage 1 when it is empty or moving into the output register.
         ST_RUN:   rd_en = rd_more_q && (!s1_q || advance);
         default:  rd_en = 1'b0;
      endcase
   end

   branch_lifo_ram #(
      .DW    (DW),
      .DEPTH (MAX_LEN),
      .AW    (LW)
   ) u_lifo (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i ({bus.init_branch1, bus.init_branch2}),
      .rd_en_i   (rd_en),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rd_more_q   <= 1'b0;
         s1_q        <= 1'b0;
         s1_idx_q    <= '0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_idx_q   <= '0;
         beta_q      <= '0;
         ob1_q       <= '0;
         ob2_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start && blk_ok) begin
                  len_q      <= bus.blk_len;
                  wr_ptr_q   <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (wr_en) begin
                  wr_ptr_q <= wr_ptr_q + LW'(1);
                  if (wr_ptr_q == len_q - LW'(1)) begin
                     in_ready_q <= 1'b0;
                     state_q    <= ST_PRIME;
                  end
               end
            end
            ST_PRIME: begin
               beta_q    <= beta_init();
               s1_q      <= 1'b1;
               s1_idx_q  <= len_q - LW'(1);
               rd_ptr_q  <= len_q - LW'(2);   // wraps for N = 1, unused then
               rd_more_q <= (len_q != LW'(1));
               state_q   <= ST_RUN;
            end
            ST_RUN: begin
               if (rd_en) begin
                  s1_q      <= 1'b1;
                  s1_idx_q  <= rd_ptr_q;
                  rd_ptr_q  <= rd_ptr_q - LW'(1);
                  rd_more_q <= (rd_ptr_q != '0);
               end else if (advance) begin
                  s1_q <= 1'b0;
               end
               if (advance) begin
                  out_valid_q <= s1_q;
                  if (s1_q) begin
                     ob1_q      <= metric_t'(rd_data[DW-1:MW]);
                     ob2_q      <= metric_t'(rd_data[MW-1:0]);
                     out_idx_q  <= s1_idx_q;
                     out_last_q <= (s1_idx_q == '0);
                  end
                  // advance with a valid beat is a transfer: step the
                  // recursion with the gamma that just left.
                  if (out_valid_q) begin
                     beta_q <= beta_step(beta_q, ob1_q, ob2_q);
                     if (out_last_q) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                     end
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.busy        = busy_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_last    = out_last_q;
   assign bus.out_idx     = out_idx_q;
   assign bus.out_branch1 = ob1_q;
   assign bus.out_branch2 = ob2_q;
   assign bus.beta_0      = beta_q[0];
   assign bus.beta_1      = beta_q[1];
   assign bus.beta_2      = beta_q[2];
   assign bus.beta_3      = beta_q[3];
   assign bus.beta_4      = beta_q[4];
   assign bus.beta_5      = beta_q[5];
   assign bus.beta_6      = beta_q[6];
   assign bus.beta_7      = beta_q[7];

endmodule

// File: tb/tb_beta_recursion.sv
// tb/tb_beta_recursion.sv - directed self-checking bench for beta_recursion
module tb_beta_recursion;
   import siso_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   beta_recursion_if bus();

   beta_recursion dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   int g1_a [MAX_LEN];
   int g2_a [MAX_LEN];
   int exp_beta [MAX_LEN][8];
   int exp_b1 [MAX_LEN];
   int exp_b2 [MAX_LEN];

   // Trellis table: state s takes b[src_a]+sgn*g and b[src_b]-sgn*g.
   int src_a [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
   int src_b [8] = '{4, 4, 5, 5, 6, 6, 7, 7};
   int gsel  [8] = '{1, 1, 2, 2, 2, 2, 1, 1};
   int sgn   [8] = '{1, -1, -1, 1, 1, -1, -1, 1};

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int w16(input int x);
      logic signed [15:0] t;
      t = x[15:0];
      return int'(t);
   endfunction

   function automatic logic signed [15:0] get_beta(input int s);
      case (s)
         0: return bus.beta_0;
         1: return bus.beta_1;
         2: return bus.beta_2;
         3: return bus.beta_3;
         4: return bus.beta_4;
         5: return bus.beta_5;
         6: return bus.beta_6;
         default: return bus.beta_7;
      endcase
   endfunction

   function automatic logic [173:0] snap();
      return {bus.beta_0, bus.beta_1, bus.beta_2, bus.beta_3, bus.beta_4,
              bus.beta_5, bus.beta_6, bus.beta_7, bus.out_branch1,
              bus.out_branch2, bus.out_idx, bus.out_last};
   endfunction

   task automatic set_init_row(input int j);
      exp_beta[j][0] = 0;
      for (int s = 1; s < 8; s++) exp_beta[j][s] = -128;
   endtask

   task automatic fill_rand(input int n);
      for (int k = 0; k < n; k++) begin
         g1_a[k] = int'($urandom_range(0, 1023)) - 512;
         g2_a[k] = int'($urandom_range(0, 1023)) - 512;
      end
   endtask

   task automatic build_model(input int n);
      int cur [8];
      int nx [8];
      int ca, cb, g, k;
      cur[0] = 0;
      for (int s = 1; s < 8; s++) cur[s] = -128;
      for (int j = 0; j < n; j++) begin
         k = n - 1 - j;
         for (int s = 0; s < 8; s++) exp_beta[j][s] = cur[s];
         exp_b1[j] = g1_a[k];
         exp_b2[j] = g2_a[k];
         for (int s = 0; s < 8; s++) begin
            g  = (gsel[s] == 1) ? g1_a[k] : g2_a[k];
            ca = w16(cur[src_a[s]] + sgn[s] * g);
            cb = w16(cur[src_b[s]] - sgn[s] * g);
            nx[s] = (cb > ca) ? cb : ca;
         end
         for (int s = 0; s < 8; s++) cur[s] = w16(nx[s] - nx[0]);
      end
   endtask

   task automatic do_start(input int len);
      bus.blk_len = LW'(len);
      bus.start   = 1'b1;
      @(negedge clk);
      bus.start   = 1'b0;
   endtask

   task automatic load_block(input int n, input bit gaps);
      int  k = 0;
      int  guard = 0;
      bit  will;
      chk("in_ready_rise", bus.in_ready, 1);
      chk("busy_rise", bus.busy, 1);
      while (k < n && guard < 20000) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
         end else begin
            bus.in_valid     = 1'b1;
            bus.init_branch1 = MW'(g1_a[k]);
            bus.init_branch2 = MW'(g2_a[k]);
         end
         will = bus.in_valid && bus.in_ready;
         @(negedge clk);
         guard++;
         if (will) k++;
      end
      bus.in_valid = 1'b0;
      chk("load_count", k, n);
      chk("in_ready_fall", bus.in_ready, 0);
      chk("latency_c1", bus.out_valid, 0);
      @(negedge clk);
      chk("latency_c2", bus.out_valid, 0);
      @(negedge clk);
      chk("latency_c3", bus.out_valid, 1);
   endtask

   task automatic check_beat(input int n, input int j);
      for (int s = 0; s < 8; s++) chk("beta", get_beta(s), exp_beta[j][s]);
      chk("out_branch1", bus.out_branch1, exp_b1[j]);
      chk("out_branch2", bus.out_branch2, exp_b2[j]);
      chk("out_idx", bus.out_idx, n - 1 - j);
      chk("out_last", bus.out_last, (j == n - 1) ? 1 : 0);
   endtask

   task automatic drain(input int n, input int nbeats, input bit rnd,
                        input int poke_at, input bit end_chk);
      int beat = 0;
      int guard = 0;
      bit stalled = 1'b0;
      bit rdy;
      logic [173:0] prev;
      while (beat < nbeats && guard < 40000) begin
         if (stalled) begin
            total++;
            assert (snap() === prev) else begin
               bad++;
               $error("FAIL stall_hold observed=%h expected=%h", snap(), prev);
            end
         end
         rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         bus.out_ready = rdy;
         bus.start     = (beat == poke_at);
         bus.blk_len   = LW'(5);
         if (bus.out_valid) begin
            if (rdy) begin
               check_beat(n, beat);
               beat++;
            end
            stalled = !rdy;
            prev    = snap();
         end else begin
            stalled = 1'b0;
         end
         @(negedge clk);
         guard++;
      end
      bus.out_ready = 1'b0;
      bus.start     = 1'b0;
      chk("drain_count", beat, nbeats);
      if (end_chk) begin
         chk("busy_fall", bus.busy, 0);
         chk("out_valid_end", bus.out_valid, 0);
      end
   endtask

   initial begin
      rst              = 1'b1;
      bus.start        = 1'b0;
      bus.blk_len      = '0;
      bus.in_valid     = 1'b0;
      bus.init_branch1 = '0;
      bus.init_branch2 = '0;
      bus.out_ready    = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_out_idx", bus.out_idx, 0);
      chk("rst_beta_0", bus.beta_0, 0);
      chk("rst_beta_7", bus.beta_7, 0);
      chk("rst_out_branch1", bus.out_branch1, 0);
      chk("rst_out_branch2", bus.out_branch2, 0);
      rst = 1'b0;
      @(negedge clk);

      // N = 1: single beat carrying the initial beta
      g1_a[0] = 5; g2_a[0] = 3;
      set_init_row(0); exp_b1[0] = 5; exp_b2[0] = 3;
      do_start(1);
      load_block(1, 1'b0);
      drain(1, 1, 1'b0, -1, 1'b1);

      // N = 2, hand-computed second beta
      g1_a[0] = 0;  g2_a[0] = 0;
      g1_a[1] = 10; g2_a[1] = 0;
      set_init_row(0); exp_b1[0] = 10; exp_b2[0] = 0;
      exp_beta[1] = '{0, -20, -138, -138, -138, -138, -128, -128};
      exp_b1[1] = 0; exp_b2[1] = 0;
      do_start(2);
      load_block(2, 1'b0);
      drain(2, 2, 1'b0, -1, 1'b1);

      // illegal lengths are ignored
      do_start(0);
      chk("len0_busy", bus.busy, 0);
      @(negedge clk);
      chk("len0_busy_later", bus.busy, 0);
      chk("len0_in_ready", bus.in_ready, 0);
      do_start(MAX_LEN + 1);
      chk("lenmax1_busy", bus.busy, 0);
      @(negedge clk);
      chk("lenmax1_busy_later", bus.busy, 0);
      chk("lenmax1_in_ready", bus.in_ready, 0);

      // N = 64 random with input gaps and output stalls
      fill_rand(64); build_model(64);
      do_start(64);
      load_block(64, 1'b1);
      drain(64, 64, 1'b1, -1, 1'b1);

      // start pulsed during RUN is ignored
      fill_rand(8); build_model(8);
      do_start(8);
      load_block(8, 1'b0);
      drain(8, 8, 1'b1, 3, 1'b1);
      @(negedge clk);
      chk("poke_ignored_busy", bus.busy, 0);

      // reset in the middle of an N = 100 block, then N = 3
      fill_rand(100); build_model(100);
      do_start(100);
      load_block(100, 1'b1);
      drain(100, 10, 1'b1, -1, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_in_ready", bus.in_ready, 0);
      chk("midrst_out_idx", bus.out_idx, 0);
      chk("midrst_beta_1", bus.beta_1, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      fill_rand(3); build_model(3);
      do_start(3);
      load_block(3, 1'b0);
      drain(3, 3, 1'b1, -1, 1'b1);

      // two back-to-back MAX_LEN blocks, second start on the cycle busy falls
      fill_rand(MAX_LEN); build_model(MAX_LEN);
      do_start(MAX_LEN);
      load_block(MAX_LEN, 1'b0);
      drain(MAX_LEN, MAX_LEN, 1'b0, -1, 1'b1);
      fill_rand(MAX_LEN); build_model(MAX_LEN);
      do_start(MAX_LEN);
      load_block(MAX_LEN, 1'b1);
      drain(MAX_LEN, MAX_LEN, 1'b1, -1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
